dma_priority_arbiter: RTL
=========================

Name: dma_priority_arbiter

Overview:
Parametrised request arbiter for the DMA controller, generalising the 8237A 4-channel priority logic to NUM_CH channels.
- Conditions hardware DREQ and software requests, resolves fixed or rotating priority, and runs the HRQ/HLDA hold handshake.
- Drives the DACK of the winning channel until the transfer-timing core signals end of service.
- Sits between the I/O device request lines and the DMA timing/control core inside the controller top.

Parameters:
NUM_CH, 4, number of DMA channels; legal range 2..16.
CHW, $clog2(NUM_CH), width of the channel index (derived; not overridden).

Ports:
Clock  in  1  system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-high reset.
dreq  in  NUM_CH  raw device requests; polarity set by dreq_active_low.
dreq_active_low  in  1  command-register bit: 1 means DREQ is asserted low.
dack_active_low  in  1  command-register bit: 1 means DACK is driven low when active.
mask  in  NUM_CH  mask register; 1 blocks the hardware DREQ of that channel.
soft_req_set  in  NUM_CH  one-cycle pulses that set the software request bits.
rot_pri  in  1  0 = fixed priority (ch0 highest); 1 = rotating priority.
hlda  in  1  hold acknowledge from the CPU/bus owner.
xfer_done  in  1  one-cycle pulse from the timing core: the granted service is finished (TC or EOP).
hrq  out  1  hold request to the CPU.
dack  out  NUM_CH  per-channel acknowledge, polarity per dack_active_low.
grant_valid  out  1  a channel currently owns the bus.
grant_ch  out  CHW  index of the granted channel; valid only while grant_valid=1.
req_status  out  NUM_CH  effective pending requests, feeding the status register.

Behaviour:
- Effective request: eff = ((dreq ^ {NUM_CH{dreq_active_low}}) & ~mask) | sw_req. Software requests ignore the mask. eff is registered once (1-cycle input latency) and drives req_status.
- Priority pointer ptr (CHW bits): ptr is the highest-priority channel, ptr+1 next, and so on, wrapping modulo NUM_CH. In fixed mode ptr is forced to 0.
- FSM states: IDLE, HOLD_REQ, GRANT, RELEASE.
  - IDLE: when registered eff != 0, go to HOLD_REQ; hrq=1 from the next cycle.
  - HOLD_REQ: hrq=1.
    - If eff drops to 0 before hlda=1: hrq deasserts and the FSM returns to IDLE.
    - When hlda=1 and eff != 0: pick the winner from the current eff and ptr, latch it into grant_ch, go to GRANT.
    - dack and grant_valid assert on the cycle after hlda is sampled high.
  - GRANT: the latched winner holds dack and grant_valid regardless of later eff changes, higher-priority arrivals or rot_pri changes. Stay here until xfer_done=1.
  - RELEASE, entered on the cycle after xfer_done:
    - dack goes inactive, grant_valid=0, hrq=0.
    - sw_req[grant_ch] is cleared.
    - If rot_pri=1, ptr = grant_ch+1 (mod NUM_CH).
    - Wait for hlda=0, then go to IDLE. A new request can raise hrq no earlier than the cycle after IDLE is re-entered.
- Simultaneous soft_req_set[ch] and clear of the same bit: set wins.
- rot_pri 1->0: ptr is forced to 0 at the next arbitration.
- xfer_done outside GRANT is ignored.
- hlda dropping during GRANT: hold the grant; the timing core owns the abort via xfer_done.
- dack = onehot(grant_ch)&{grant_valid} ^ {NUM_CH{dack_active_low}}. The polarity inputs are quasi-static; changing them mid-grant is undefined.
- Reset, asynchronous and effective immediately even mid-operation:
  - state=IDLE, hrq=0, grant_valid=0, grant_ch=0.
  - ptr=0, sw_req=0, registered eff=0, req_status=0.
  - dack = {NUM_CH{dack_active_low}}, i.e. all channels inactive.

Decomposition:
- Package dma_arb_pkg: arb_state_e enum (IDLE, HOLD_REQ, GRANT, RELEASE) and a function onehot_to_idx.
- Sub-module dma_rr_picker: purely combinational; inputs req[NUM_CH] and ptr; outputs found and idx. It is instantiated once and reused for both fixed (ptr=0) and rotating modes.

Test Plan:
All scenarios use NUM_CH=4 and active-high polarity unless stated.
1. Basic handshake: after reset, dreq=0001, hlda raised 2 cycles after hrq -> hrq=1 two cycles after dreq; dack=0001, grant_ch=0 the cycle after hlda; xfer_done pulse -> dack=0000, hrq=0 the next cycle.
2. Fixed priority: dreq=1010 held, rot_pri=0 -> grant ch1 first; after release and hlda=0, re-request -> grant ch1 again, ch3 starves.
3. Rotating priority: dreq=1111 held, rot_pri=1, four services -> grant_ch sequence 0,1,2,3 and then 0 again.
4. Mask vs software request: mask=0001, dreq=0001 -> hrq stays 0 for 10 cycles; soft_req_set=0001 pulse -> ch0 granted; after xfer_done, req_status=0000.
5. Polarity: dreq_active_low=1, dack_active_low=1, dreq=1011 (ch2 requesting) -> dack=1011 during the grant and 1111 otherwise.
6. Withdrawal and reset:
   - dreq removed while in HOLD_REQ, hlda still 0 -> hrq returns to 0 with no dack.
   - Reset asserted during GRANT -> hrq=0 and dack inactive before the next Clock edge; ptr=0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA request arbiter.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHoldReq,
        StGrant,
        StRelease
    } arb_state_e;

    // OR-encoder: exact for a one-hot input, zero for an all-zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational priority picker: first requester at or after i_ptr, wrapping.
module dma_rr_picker #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CHW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CHW-1:0]    i_ptr,
    output logic              o_found,
    output logic [CHW-1:0]    o_idx
);
    import dma_arb_pkg::*;

    logic [NUM_CH-1:0] w_oh;
    logic [CHW-1:0]    w_c;

    always_comb begin
        w_oh    = '0;
        w_c     = '0;
        o_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_c = CHW'((32'(i_ptr) + k) % NUM_CH);
            if (!o_found && i_req[w_c]) begin
                o_found  = 1'b1;
                w_oh[w_c] = 1'b1;
            end
        end
        o_idx = CHW'(onehot_to_idx(16'(w_oh)));
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: request conditioning, fixed/rotating priority and
// the HRQ/HLDA hold handshake, holding DACK until the timing core finishes.
module dma_priority_arbiter #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CHW    = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic              i_dreq_active_low,
    input  logic              i_dack_active_low,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [NUM_CH-1:0] i_soft_req_set,
    input  logic              i_rot_pri,
    input  logic              i_hlda,
    input  logic              i_xfer_done,
    output logic              o_hrq,
    output logic [NUM_CH-1:0] o_dack,
    output logic              o_grant_valid,
    output logic [CHW-1:0]    o_grant_ch,
    output logic [NUM_CH-1:0] o_req_status
);
    import dma_arb_pkg::*;

    arb_state_e        r_state, w_state_d;
    logic [NUM_CH-1:0] r_eff, w_eff_d;
    logic [NUM_CH-1:0] r_sw_req, w_sw_req_d;
    logic [CHW-1:0]    r_grant_ch, w_grant_ch_d;
    logic [CHW-1:0]    r_ptr, w_ptr_d;
    logic [CHW-1:0]    w_pick_ptr, w_pick_idx;
    logic              w_pick_found;
    logic [NUM_CH-1:0] w_grant_oh;

    assign w_eff_d    = ((i_dreq ^ {NUM_CH{i_dreq_active_low}}) & ~i_mask) | r_sw_req;
    assign w_pick_ptr = i_rot_pri ? r_ptr : '0;

    dma_rr_picker #(
        .NUM_CH (NUM_CH),
        .CHW    (CHW)
    ) u_picker (
        .i_req   (r_eff),
        .i_ptr   (w_pick_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_d    = r_state;
        w_grant_ch_d = r_grant_ch;
        w_ptr_d      = i_rot_pri ? r_ptr : '0;
        w_sw_req_d   = r_sw_req;
        case (r_state)
            StIdle: begin
                if (|r_eff) w_state_d = StHoldReq;
            end
            StHoldReq: begin
                if (!(|r_eff)) begin
                    w_state_d = StIdle;
                end else if (i_hlda && w_pick_found) begin
                    w_grant_ch_d = w_pick_idx;
                    w_state_d    = StGrant;
                end
            end
            StGrant: begin
                if (i_xfer_done) begin
                    w_state_d              = StRelease;
                    w_sw_req_d[r_grant_ch] = 1'b0;
                    if (i_rot_pri) begin
                        w_ptr_d = (r_grant_ch == CHW'(NUM_CH - 1)) ? '0 : r_grant_ch + 1'b1;
                    end
                end
            end
            StRelease: begin
                if (!i_hlda) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // A new software request in the same cycle as the clear must survive.
        w_sw_req_d = w_sw_req_d | i_soft_req_set;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_eff      <= '0;
            r_sw_req   <= '0;
            r_grant_ch <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_eff      <= w_eff_d;
            r_sw_req   <= w_sw_req_d;
            r_grant_ch <= w_grant_ch_d;
            r_ptr      <= w_ptr_d;
        end
    end

    assign w_grant_oh    = NUM_CH'(1) << r_grant_ch;
    assign o_hrq         = (r_state == StHoldReq) || (r_state == StGrant);
    assign o_grant_valid = (r_state == StGrant);
    assign o_grant_ch    = r_grant_ch;
    assign o_req_status  = r_eff;
    assign o_dack        = (o_grant_valid ? w_grant_oh : '0) ^ {NUM_CH{i_dack_active_low}};

endmodule
